// File: rtl/riscv_if_if.sv
// Instruction-memory request/grant/response bus between the fetch stage (master)
// and instruction memory (slave).
interface riscv_if_if #(
  parameter int XLEN = 32
);
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_gnt;
  logic            imem_rvalid;
  logic [XLEN-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

// File: rtl/riscv_if.sv
// RISC-V instruction-fetch stage: one outstanding imem request, 2-entry return
// queue, registered instruction/pc/valid/exception towards decode.
module riscv_if #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter logic [XLEN-1:0] NOP      = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst,
  riscv_if_if.master      imem,
  input  logic            i_stall,
  input  logic            i_redirect,
  input  logic [XLEN-1:0] i_redirect_pc,
  output logic [XLEN-1:0] o_instruction,
  output logic [XLEN-1:0] o_pc,
  output logic            o_valid,
  output logic            o_exception
);

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HALT = 2'd3
  } state_t;

  localparam logic [XLEN-1:0] PC_STEP = {{(XLEN-3){1'b0}}, 3'b100};

  state_t          r_state;
  state_t          w_state_nxt;
  logic [XLEN-1:0] r_fetch_pc;
  logic [XLEN-1:0] r_req_pc;
  logic            r_discard;
  logic [XLEN-1:0] r_q_word [2];
  logic [XLEN-1:0] r_q_addr [2];
  logic            r_head;
  logic [1:0]      r_count;
  logic [XLEN-1:0] r_instruction;
  logic [XLEN-1:0] r_pc;
  logic            r_valid;
  logic            r_exception;

  logic            w_outstanding;
  logic [2:0]      w_occupancy;
  logic            w_credit;
  logic            w_req;
  logic            w_grant;
  logic            w_resp;
  logic            w_push;
  logic            w_pop;
  logic            w_keep_pending;
  logic            w_wr_idx;

  // WAIT is the only state with a request in flight.
  assign w_outstanding  = (r_state == S_WAIT);
  assign w_occupancy    = {1'b0, r_count} + {2'b00, w_outstanding};
  assign w_credit       = (w_occupancy < 3'd2);
  assign w_req          = (r_state == S_REQ) && w_credit;
  assign w_grant        = w_req && imem.imem_gnt;
  assign w_resp         = w_outstanding && imem.imem_rvalid;
  assign w_push         = w_resp && !r_discard && !i_redirect;
  assign w_pop          = !i_redirect && !i_stall && (r_state != S_HALT) && (r_count != 2'd0);
  assign w_keep_pending = (w_outstanding && !imem.imem_rvalid) || w_grant;
  assign w_wr_idx       = r_head ^ r_count[0];

  assign imem.imem_req  = w_req;
  assign imem.imem_addr = r_fetch_pc;

  assign o_instruction  = r_instruction;
  assign o_pc           = r_pc;
  assign o_valid        = r_valid;
  assign o_exception    = r_exception;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_BOOT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // A misaligned target reached through a discarded response still ends in HALT.
  always_comb begin
    w_state_nxt = r_state;
    if (i_redirect) begin
      if (w_keep_pending) begin
        w_state_nxt = S_WAIT;
      end else if (i_redirect_pc[1:0] != 2'b00) begin
        w_state_nxt = S_HALT;
      end else begin
        w_state_nxt = S_REQ;
      end
    end else begin
      case (r_state)
        S_BOOT: w_state_nxt = S_REQ;
        S_REQ: begin
          if (w_grant) begin
            w_state_nxt = S_WAIT;
          end else begin
            w_state_nxt = S_REQ;
          end
        end
        S_WAIT: begin
          if (!imem.imem_rvalid) begin
            w_state_nxt = S_WAIT;
          end else if (r_fetch_pc[1:0] != 2'b00) begin
            w_state_nxt = S_HALT;
          end else begin
            w_state_nxt = S_REQ;
          end
        end
        S_HALT:  w_state_nxt = S_HALT;
        default: w_state_nxt = S_BOOT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fetch_pc <= RESET_PC;
      r_req_pc   <= RESET_PC;
      r_discard  <= 1'b0;
    end else if (i_redirect) begin
      r_fetch_pc <= i_redirect_pc;
      r_discard  <= w_keep_pending;
    end else begin
      if (w_grant) begin
        r_req_pc   <= r_fetch_pc;
        r_fetch_pc <= r_fetch_pc + PC_STEP;
      end
      if (w_resp) begin
        r_discard <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        r_q_word[i] <= NOP;
        r_q_addr[i] <= RESET_PC;
      end
      r_head  <= 1'b0;
      r_count <= 2'd0;
    end else if (i_redirect) begin
      r_head  <= 1'b0;
      r_count <= 2'd0;
    end else begin
      if (w_push) begin
        r_q_word[w_wr_idx] <= imem.imem_rdata;
        r_q_addr[w_wr_idx] <= r_req_pc;
      end
      if (w_pop) begin
        r_head <= ~r_head;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Decode-facing registers: redirect bubbles beat stall; HALT reports the faulting target.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_instruction <= NOP;
      r_pc          <= RESET_PC;
      r_valid       <= 1'b0;
      r_exception   <= 1'b0;
    end else if (i_redirect) begin
      r_instruction <= NOP;
      r_valid       <= 1'b0;
      r_exception   <= 1'b0;
    end else if (!i_stall) begin
      if (r_state == S_HALT) begin
        r_instruction <= NOP;
        r_pc          <= r_fetch_pc;
        r_valid       <= 1'b0;
        r_exception   <= 1'b1;
      end else if (w_pop) begin
        r_instruction <= r_q_word[r_head];
        r_pc          <= r_q_addr[r_head];
        r_valid       <= 1'b1;
        r_exception   <= 1'b0;
      end else begin
        r_instruction <= NOP;
        r_valid       <= 1'b0;
        r_exception   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_riscv_if.sv
// Bench for riscv_if: directed scenarios plus random stall/grant/latency/redirect
// traffic checked against an in-order delivery model of the fetch stream.
module tb_riscv_if;

  localparam logic [31:0] NOP_W = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] instruction;
  logic [31:0] pc;
  logic        valid;
  logic        exception;

  riscv_if_if #(.XLEN(32)) imem_bus ();

  riscv_if #(.XLEN(32)) u_dut (
    .clk          (clk),
    .rst          (rst),
    .imem         (imem_bus),
    .i_stall      (stall),
    .i_redirect   (redirect),
    .i_redirect_pc(redirect_pc),
    .o_instruction(instruction),
    .o_pc         (pc),
    .o_valid      (valid),
    .o_exception  (exception)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int n_deliv = 0;

  // memory model
  bit          mem_pending;
  logic [31:0] mem_addr;
  int          mem_delay;
  int          gnt_pct = 100;
  int          lat_min = 0;
  int          lat_max = 0;
  bit          last_grant;
  logic [31:0] last_grant_addr;

  // stimulus knobs
  bit          k_stall;
  bit          k_rdr;
  logic [31:0] k_rdr_pc;
  bit          k_rdr_on_req;
  bit          k_rdr_gnt;
  bit          k_stray;

  // delivery model
  logic [31:0] sb_exp_pc;
  logic [31:0] sb_halt_pc;
  bit          sb_halted;
  bit          sb_bubble;
  bit          sb_prev_stall;
  bit          sb_prev_rdr;
  logic [31:0] sb_prev_instr;
  logic [31:0] sb_prev_pc;
  logic        sb_prev_valid;
  logic        sb_prev_exc;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_0000) return 32'h0050_0093;
    return {a[15:0], ~a[31:16]} ^ 32'h5A3C_0F81;
  endfunction

  function automatic logic [31:0] pick_target();
    int          sel;
    logic [31:0] t;
    sel = $urandom_range(9);
    t   = 32'h0000_1000 | ($urandom & 32'h0000_0FFC);
    if (sel == 0) t = t | 32'($urandom_range(3, 1));
    if (sel == 1) t = 32'hFFFF_FFF0;
    return t;
  endfunction

  // One clock cycle: drive inputs at negedge, sample #1 later, update models for the coming edge.
  task automatic cycle();
    bit g;
    bit rv;
    bit rdr;
    @(negedge clk);
    rv  = mem_pending && (mem_delay == 0);
    g   = ($urandom_range(99) < gnt_pct);
    rdr = k_rdr;
    if (k_rdr_on_req && imem_bus.imem_req) begin
      rdr          = 1'b1;
      g            = k_rdr_gnt;
      k_rdr_on_req = 1'b0;
    end
    k_rdr                = 1'b0;
    imem_bus.imem_gnt    = g;
    imem_bus.imem_rvalid = rv || k_stray;
    imem_bus.imem_rdata  = rv ? mem_word(mem_addr) : 32'hDEAD_BEEF;
    k_stray              = 1'b0;
    stall                = k_stall;
    redirect             = rdr;
    redirect_pc          = k_rdr_pc;
    #1;
    if (mem_pending) check_eq("req_while_pending", imem_bus.imem_req, 1'b0);
    if (sb_prev_stall && !sb_prev_rdr) begin
      check_eq("stall_hold_instr", instruction, sb_prev_instr);
      check_eq("stall_hold_pc", pc, sb_prev_pc);
      check_eq("stall_hold_valid", valid, sb_prev_valid);
      check_eq("stall_hold_exc", exception, sb_prev_exc);
    end
    if (sb_bubble) begin
      check_eq("bubble_valid", valid, 1'b0);
      check_eq("bubble_instr", instruction, NOP_W);
      check_eq("bubble_exc", exception, 1'b0);
    end else if (sb_halted) begin
      check_eq("halt_valid", valid, 1'b0);
      check_eq("halt_req", imem_bus.imem_req, 1'b0);
      if (exception) check_eq("halt_pc", pc, sb_halt_pc);
    end else begin
      check_eq("exc_clear", exception, 1'b0);
      if (valid && !stall) begin
        check_eq("deliv_pc", pc, sb_exp_pc);
        check_eq("deliv_instr", instruction, mem_word(sb_exp_pc));
        sb_exp_pc = sb_exp_pc + 32'd4;
        n_deliv++;
      end
    end
    sb_prev_stall = stall;
    sb_prev_rdr   = rdr;
    sb_prev_instr = instruction;
    sb_prev_pc    = pc;
    sb_prev_valid = valid;
    sb_prev_exc   = exception;
    sb_bubble     = 1'b0;
    if (rdr) begin
      sb_exp_pc  = k_rdr_pc;
      sb_halt_pc = k_rdr_pc;
      sb_halted  = (k_rdr_pc[1:0] != 2'b00);
      sb_bubble  = 1'b1;
    end
    last_grant = imem_bus.imem_req && g;
    if (rv) mem_pending = 1'b0;
    else if (mem_pending) mem_delay--;
    if (last_grant) begin
      mem_pending     = 1'b1;
      mem_addr        = imem_bus.imem_addr;
      last_grant_addr = imem_bus.imem_addr;
      mem_delay       = $urandom_range(lat_max, lat_min);
    end
  endtask

  task automatic apply_reset(input bit stray);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check_eq("rst_req", imem_bus.imem_req, 1'b0);
    check_eq("rst_addr", imem_bus.imem_addr, 32'h0);
    check_eq("rst_instr", instruction, NOP_W);
    check_eq("rst_pc", pc, 32'h0);
    check_eq("rst_valid", valid, 1'b0);
    check_eq("rst_exc", exception, 1'b0);
    imem_bus.imem_gnt = 1'b0; imem_bus.imem_rvalid = 1'b0; imem_bus.imem_rdata = 32'h0;
    stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    k_stall = 1'b0; k_rdr = 1'b0; k_rdr_on_req = 1'b0; k_stray = 1'b0;
    mem_pending = 1'b0; last_grant = 1'b0;
    sb_exp_pc = 32'h0; sb_halted = 1'b0; sb_bubble = 1'b0;
    sb_prev_stall = 1'b0; sb_prev_rdr = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    imem_bus.imem_rvalid = stray;
    imem_bus.imem_rdata  = 32'hDEAD_BEEF;
    #1 check_eq("boot_req", imem_bus.imem_req, 1'b0);
  endtask

  task automatic boot_sequence(input bit stray);
    gnt_pct = 100; lat_min = 0; lat_max = 0;
    k_stray = stray;
    cycle();
    check_eq("first_req", imem_bus.imem_req, 1'b1);
    check_eq("first_addr", imem_bus.imem_addr, 32'h0);
    cycle();
    cycle();
    check_eq("second_req", imem_bus.imem_req, 1'b1);
    check_eq("second_addr", imem_bus.imem_addr, 32'h4);
    cycle();
    check_eq("first_valid", valid, 1'b1);
    check_eq("first_instr", instruction, 32'h0050_0093);
    check_eq("first_pc", pc, 32'h0);
  endtask

  task automatic wait_valid(input string tag, input logic [31:0] exp);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 40 && !seen; n++) begin
      cycle();
      if (valid && !stall) seen = 1'b1;
    end
    check_eq({tag, "_seen"}, seen, 1'b1);
    if (seen) check_eq(tag, pc, exp);
  endtask

  task automatic wait_grant(input string tag, input bit match, input logic [31:0] a);
    bit found;
    found = 1'b0;
    for (int n = 0; n < 30 && !found; n++) begin
      cycle();
      if (last_grant && (!match || last_grant_addr == a)) found = 1'b1;
    end
    check_eq(tag, found, 1'b1);
  endtask

  task automatic fire_on_req(input string tag, input logic [31:0] tgt, input bit gnt_v);
    k_rdr_pc = tgt; k_rdr_gnt = gnt_v; k_rdr_on_req = 1'b1;
    for (int n = 0; n < 20 && k_rdr_on_req; n++) cycle();
    check_eq(tag, k_rdr_on_req, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    apply_reset(1'b0);
    boot_sequence(1'b0);

    // stall while streaming from 0x100
    k_rdr = 1'b1; k_rdr_pc = 32'h0000_0100;
    cycle();
    wait_valid("stream_pc", 32'h0000_0100);
    k_stall = 1'b1;
    repeat (6) cycle();
    check_eq("stall_req_drop", imem_bus.imem_req, 1'b0);
    k_stall = 1'b0;
    wait_valid("after_stall_pc0", 32'h0000_0104);
    wait_valid("after_stall_pc1", 32'h0000_0108);

    // redirect while 0x10 is outstanding
    lat_min = 3; lat_max = 3;
    k_rdr = 1'b1; k_rdr_pc = 32'h0000_0010;
    cycle();
    wait_grant("grant_0x10", 1'b1, 32'h0000_0010);
    k_rdr = 1'b1; k_rdr_pc = 32'h0000_0200;
    cycle();
    wait_valid("discard_pc", 32'h0000_0200);

    // redirect on the grant cycle
    lat_min = 0; lat_max = 1;
    fire_on_req("rdr_gnt_fire", 32'h0000_0400, 1'b1);
    check_eq("rdr_gnt_same_cycle", last_grant, 1'b1);
    wait_valid("rdr_gnt_pc", 32'h0000_0400);

    // misaligned target halts, aligned redirect resumes
    fire_on_req("halt_fire", 32'h0000_0202, 1'b0);
    cycle();
    check_eq("halt_bubble_exc", exception, 1'b0);
    check_eq("halt_req0", imem_bus.imem_req, 1'b0);
    cycle();
    check_eq("halt_exc", exception, 1'b1);
    check_eq("halt_pc_val", pc, 32'h0000_0202);
    repeat (3) cycle();
    check_eq("halt_exc_hold", exception, 1'b1);
    k_rdr = 1'b1; k_rdr_pc = 32'h0000_0300;
    cycle();
    cycle();
    check_eq("resume_exc", exception, 1'b0);
    wait_valid("resume_pc", 32'h0000_0300);

    // address wrap
    fire_on_req("wrap_fire", 32'hFFFF_FFFC, 1'b0);
    wait_grant("wrap_grant_top", 1'b1, 32'hFFFF_FFFC);
    wait_grant("wrap_grant_next", 1'b0, 32'h0);
    check_eq("wrap_addr", last_grant_addr, 32'h0);
    repeat (6) cycle();

    // reset while a response is outstanding, stray rvalid after release
    k_rdr = 1'b1; k_rdr_pc = 32'h0000_0500;
    cycle();
    wait_valid("pre_reset_pc", 32'h0000_0500);
    lat_min = 3; lat_max = 3;
    wait_grant("pre_reset_grant", 1'b0, 32'h0);
    apply_reset(1'b1);
    boot_sequence(1'b1);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) begin
        gnt_pct = $urandom_range(100, 30);
        lat_min = 0;
        lat_max = $urandom_range(3, 0);
      end
      k_stall = ($urandom_range(99) < 25);
      if ($urandom_range(99) < (sb_halted ? 10 : 3)) begin
        k_rdr    = 1'b1;
        k_rdr_pc = pick_target();
      end
      cycle();
    end
    check_eq("progress", (n_deliv > 200), 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/riscv_if.md
# riscv_if

Instruction-fetch stage of the RISC-V pipeline, directly upstream of instruction decode. It owns the fetch PC and issues word requests to instruction memory over a request/grant/response handshake. Returned words are buffered in a 2-entry queue, and `instruction`/`pc` are presented to decode with a valid flag; bubbles are presented as NOP. It also handles branch/jump redirects, downstream stalls and misaligned-target exceptions.

## Interface
Parameters:
- `XLEN`, 32, data/address width
- `RESET_PC`, 32'h0000_0000, first fetch address after reset
- `NOP`, 32'h0000_0013, bubble encoding (`addi x0,x0,0`)

Ports:
- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  asynchronous, active-low reset
- `imem_req`  out  1  fetch request; held until granted
- `imem_addr`  out  XLEN  word address of the request (= fetch PC)
- `imem_gnt`  in  1  memory accepts the request this cycle
- `imem_rvalid`  in  1  response valid; arrives at least 1 cycle after grant
- `imem_rdata`  in  XLEN  instruction word
- `stall`  in  1  decode cannot accept; hold outputs
- `redirect`  in  1  branch/jump taken; 1-cycle pulse
- `redirect_pc`  in  XLEN  new fetch target
- `instruction`  out  XLEN  registered instruction to decode
- `pc`  out  XLEN  registered address of `instruction`
- `valid`  out  1  `instruction` is real (not a bubble)
- `exception`  out  1  instruction-address-misaligned fault

## Operation
- Holds at most one outstanding memory request. Queue `q` has 2 entries of {word, addr}. `credit = (count + outstanding) < 2`.
- FSM states:
  - `BOOT` (reset state): `imem_req=0`. Goes to `REQ` on the next edge.
  - `REQ`: `imem_req = credit`, `imem_addr = fetch_pc`.
    - Grant while `imem_req`=1: `req_pc <= fetch_pc`, `fetch_pc <= fetch_pc + 4` (mod 2^XLEN, wraps silently), go to `WAIT`.
  - `WAIT`: `imem_req=0`.
    - On `imem_rvalid`: push {`imem_rdata`, `req_pc`} unless `discard`. Clear `discard`. Go to `REQ`.
  - `HALT`: `imem_req=0`. Leaves only on a redirect.
- Redirect, any state, highest priority:
  - `fetch_pc <= redirect_pc`; queue flushed (`count <= 0`).
  - `discard <= 1` if a request is outstanding after this edge and its response has not arrived this cycle. This includes a grant in the same cycle: go to `WAIT`.
  - Otherwise go to `REQ`, or to `HALT` if `redirect_pc[1:0] != 0`.
  - Output registers load `NOP`, `valid=0`, ignoring `stall`.
- Output update, when `!stall` and no redirect:
  - Queue non-empty: pop the head into `instruction`/`pc` and set `valid=1`.
  - Queue empty: `instruction=NOP`, `valid=0`, `pc` unchanged.
  - In `HALT`: `exception=1` and `pc` = faulting target.
- While `stall`: `instruction`, `pc`, `valid` and `exception` hold.
- Push and pop in the same cycle are allowed: count is unchanged, FIFO order is preserved.
- A push is never attempted when full, because `credit` prevents it.

## Timing
- Reset (`rst`=0): state `BOOT`, `fetch_pc=RESET_PC`, `count=0`, `discard=0`, `imem_req=0`, `imem_addr=RESET_PC`, `instruction=NOP`, `pc=RESET_PC`, `valid=0`, `exception=0`.
- Reset asserted mid-transaction: the outstanding response is lost. After release, stray `imem_rvalid` in `BOOT`/`REQ` is ignored.
- First `imem_req` is asserted in the 2nd cycle after reset release.
- Latency: response accepted at edge E with queue empty and no stall → `valid=1` after edge E+1.
- Steady throughput with 1-cycle memory: one instruction per 2 cycles (grant, response).
- Redirect at edge R: outputs are a bubble after R. The first new request is issued in the cycle after R, or after the discarded response returns.
- `exception` is a registered level; it holds in `HALT` until a redirect clears it.

## Test plan
- Reset release, memory grants immediately and returns 32'h00500093 one cycle later → `imem_addr`=0, then `valid=1`, `instruction`=32'h00500093, `pc`=0. Next request at addr 4.
- `stall` held 6 cycles during streaming from 0x100 → queue fills to 2, `imem_req` drops, outputs frozen. On release, 0x104 and 0x108 emerge in order with no loss or duplication.
- Redirect to 0x200 while a request to 0x10 is outstanding → the 0x10 response is discarded, `valid=0` bubble, then next valid `pc`=0x200.
- Redirect on the same cycle as grant → the granted response is dropped; first valid `pc` is the redirect target.
- Redirect to 0x202 → `HALT`, `exception=1`, `pc`=0x202, `imem_req=0`. A later redirect to 0x300 clears `exception` and resumes fetch at 0x300.
- Fetch at 32'hFFFF_FFFC → next `imem_addr`=0 (wrap). Also assert `rst` low mid-`WAIT` → all outputs return to their reset values immediately.
